// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory bus.
// It is backed by a 64-bit-wide RAM and inserts WAIT_STATES extra cycles before each access.
// It serves byte, half, word and double accesses, little-endian.
// Read data is returned right-justified and zero-extended.
// Optional feature macro: DMEM_ERR_CHECK_EN. When defined, misaligned and
// out-of-range accesses are rejected with an error pulse. When undefined,
// addresses are aligned down and wrap modulo the RAM size.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  output logic [63:0] dmem_din,
  input  logic [1:0]  dmem_write_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic        dmem_cycle_complete,
  output logic        dmem_error
);

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-enable pattern of an access, before shifting into its lane.
  function automatic logic [7:0] size_bytes(input logic [1:0] w);
    logic [7:0] m;
    case (w)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      2'd3:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Bit mask that zero-extends right-justified read data.
  function automatic logic [63:0] width_mask(input logic [1:0] w);
    logic [63:0] m;
    case (w)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      2'd3:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // Lane after forcing the bits below the access size to zero.
  function automatic logic [2:0] align_lane(input logic [2:0] lane, input logic [1:0] w);
    logic [2:0] l;
    case (w)
      2'd0:    l = lane;
      2'd1:    l = {lane[2:1], 1'b0};
      2'd2:    l = {lane[2], 2'b00};
      2'd3:    l = 3'd0;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        write_q, write_d;
  logic        dual_q, dual_d;
  logic [63:0] din_q, din_d;
  logic        complete_q, complete_d;
  logic        error_q, error_d;

  logic [63:0] mem_q [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx_s;
  logic [2:0]  lane_s;
  logic        reject_s;
  logic [63:0] rdword_s;
  logic [63:0] rdata_s;
  logic [7:0]  be_s;
  logic [63:0] wbits_s;
  logic [63:0] wmerged_s;
  logic        mem_we_s;

  assign idx_s = addr_q[DEPTH_LOG2+2:3];

`ifdef DMEM_ERR_CHECK_EN
  logic misalign_s;
  logic oor_s;
  assign misalign_s = (align_lane(addr_q[2:0], width_q) != addr_q[2:0]);
  assign oor_s      = |addr_q[63:DEPTH_LOG2+3];
  assign lane_s     = addr_q[2:0];
  assign reject_s   = dual_q | misalign_s | oor_s;
`else
  logic unused_addr_s;
  assign unused_addr_s = ^addr_q[63:DEPTH_LOG2+3];
  assign lane_s        = align_lane(addr_q[2:0], width_q);
  assign reject_s      = dual_q;
`endif

  // Read path: select the addressed doubleword, shift the lane down and zero-extend.
  always_comb begin
    rdword_s = mem_q[idx_s];
    rdata_s  = (rdword_s >> {lane_s, 3'b000}) & width_mask(width_q);
  end

  // Write path: merge the shifted write data into only the addressed bytes.
  always_comb begin
    wbits_s = 64'h0;
    be_s    = size_bytes(width_q) << lane_s;
    for (int b = 0; b < 8; b++) begin
      wbits_s[8*b +: 8] = {8{be_s[b]}};
    end
    wmerged_s = (rdword_s & ~wbits_s) | ((wdata_q << {lane_s, 3'b000}) & wbits_s);
  end

  // Next-state and output logic of the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    width_d    = width_q;
    write_d    = write_q;
    dual_d     = dual_q;
    din_d      = din_q;
    complete_d = 1'b0;
    error_d    = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_rstrobe || dmem_wstrobe) begin
          addr_d  = dmem_addr;
          wdata_d = dmem_dout;
          width_d = dmem_write_width;
          write_d = dmem_wstrobe & ~dmem_rstrobe;
          dual_d  = dmem_wstrobe & dmem_rstrobe;
          cnt_d   = WAIT_LOAD;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d    = ST_RESP;
          complete_d = 1'b1;
          error_d    = reject_s;
          if (write_q) begin
            mem_we_s = ~reject_s;
          end else begin
            din_d = reject_s ? 64'h0 : rdata_s;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and registered outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      width_q    <= 2'd0;
      write_q    <= 1'b0;
      dual_q     <= 1'b0;
      din_q      <= 64'h0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      width_q    <= width_d;
      write_q    <= write_d;
      dual_q     <= dual_d;
      din_q      <= din_d;
      complete_q <= complete_d;
      error_q    <= error_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wmerged_s;
    end
  end

  assign dmem_din            = din_q;
  assign dmem_cycle_complete = complete_q;
  assign dmem_error          = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Expected responses are pushed to a scoreboard.
// They are pushed when a request is driven and compared when the complete pulse is seen.
module tb_dmem_responder;

  localparam int DL = 12;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] addr = 64'h0;
  logic [63:0] dout = 64'h0;
  logic [63:0] din;
  logic [1:0]  width = 2'd0;
  logic        rs = 1'b0;
  logic        wsb = 1'b0;
  logic        complete;
  logic        error;

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(WS)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dmem_addr           (addr),
    .dmem_dout           (dout),
    .dmem_din            (din),
    .dmem_write_width    (width),
    .dmem_rstrobe        (rs),
    .dmem_wstrobe        (wsb),
    .dmem_cycle_complete (complete),
    .dmem_error          (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] din;
    logic        err;
    int          due;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mdl[int];
  logic [63:0] last_din = 64'h0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Compare every completed access against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && complete) begin
      if (sb.size() == 0) begin
        check("spurious_complete", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_err"}, {63'd0, error}, {63'd0, e.err});
        check({e.tag, "_din"}, din, e.din);
        check({e.tag, "_cyc"}, 64'(cyc), 64'(e.due));
      end
    end else if (rst_n && error) begin
      check("stray_error", 64'd1, 64'd0);
    end
  end

  // Drive one request, update the reference model and push the expected response.
  task automatic issue(input string tag, input logic rd, input logic wr,
                       input logic [1:0] w, input logic [63:0] a, input logic [63:0] d);
    exp_t        e;
    int          size;
    int          idx;
    logic [2:0]  lane;
    logic [2:0]  amask;
    logic [63:0] wd;
    logic [63:0] msk;
    logic        err;
    size  = 1 << w;
    amask = 3'(size - 1);
    idx   = int'(a[DL+2:3]);
    err   = rd & wr;
`ifdef DMEM_ERR_CHECK_EN
    lane = a[2:0];
    if ((a[2:0] & amask) != 3'd0) err = 1'b1;
    if (a[63:DL+3] != '0) err = 1'b1;
`else
    lane = a[2:0] & ~amask;
`endif
    if (wr && !rd) begin
      if (!err) begin
        wd = mdl.exists(idx) ? mdl[idx] : 64'h0;
        for (int i = 0; i < size; i++) wd[8*(int'(lane)+i) +: 8] = d[8*i +: 8];
        mdl[idx] = wd;
      end
    end else begin
      if (err) begin
        last_din = 64'h0;
      end else begin
        msk = (w == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8*size)) - 64'h1);
        last_din = (mdl[idx] >> (8*int'(lane))) & msk;
      end
    end
    e.din = last_din;
    e.err = err;
    e.tag = tag;
    @(negedge clk);
    addr  = a;
    dout  = d;
    width = w;
    rs    = rd;
    wsb   = wr;
    e.due = cyc + 2 + WS;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rs  = 1'b0;
    wsb = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic xfer(input string tag, input logic rd, input logic wr,
                      input logic [1:0] w, input logic [63:0] a, input logic [63:0] d);
    issue(tag, rd, wr, w, a, d);
    wait_idle();
  endtask

  initial begin
    logic [63:0] saved;
    logic [1:0]  rw;
    logic [2:0]  rl;
    logic [63:0] ra;
    logic [63:0] rdat;
    repeat (3) @(negedge clk);
    check("rst_din", din, 64'h0);
    check("rst_complete", {63'd0, complete}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer("wr_d40", 1'b0, 1'b1, 2'd3, 64'h40, 64'h1122_3344_5566_7788);
    xfer("rd_d40", 1'b1, 1'b0, 2'd3, 64'h40, 64'h0);
    xfer("wr_b43", 1'b0, 1'b1, 2'd0, 64'h43, 64'hFFFF_FFFF_FFFF_FFAA);
    xfer("rd_w40", 1'b1, 1'b0, 2'd2, 64'h40, 64'h0);
    xfer("rd_h46", 1'b1, 1'b0, 2'd1, 64'h46, 64'h0);

    // Misaligned and out-of-range accesses.
    xfer("wr_d00", 1'b0, 1'b1, 2'd3, 64'h0, 64'h0F0E_0D0C_0B0A_0908);
    xfer("rd_w42", 1'b1, 1'b0, 2'd2, 64'h42, 64'h0);
    xfer("wr_oob", 1'b0, 1'b1, 2'd3, 64'h0000_0001_0000_0000, 64'hCAFE_F00D_1234_5678);
    xfer("rd_d00", 1'b1, 1'b0, 2'd3, 64'h0, 64'h0);

    // Both strobes together are rejected.
    xfer("dual", 1'b1, 1'b1, 2'd3, 64'h40, 64'hDEAD_BEEF_DEAD_BEEF);
    xfer("rd_after_dual", 1'b1, 1'b0, 2'd3, 64'h40, 64'h0);

    // A strobe that arrives in WAIT is ignored.
    issue("rd_busy", 1'b1, 1'b0, 2'd3, 64'h40, 64'h0);
    @(negedge clk);
    @(negedge clk);
    addr = 64'h40; dout = 64'h5555_5555_5555_5555; width = 2'd3; wsb = 1'b1;
    @(posedge clk);
    #1;
    wsb = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    xfer("rd_after_busy", 1'b1, 1'b0, 2'd3, 64'h40, 64'h0);

    // Reset in WAIT aborts a write.
    saved = mdl[8];
    issue("wr_abort", 1'b0, 1'b1, 2'd0, 64'h41, 64'h0000_0000_0000_00EE);
    void'(sb.pop_back());
    mdl[8] = saved;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_din = 64'h0;
    @(negedge clk);
    check("post_rst_din", din, 64'h0);
    check("post_rst_complete", {63'd0, complete}, 64'd0);
    check("post_rst_error", {63'd0, error}, 64'd0);
    repeat (8) @(negedge clk);
    xfer("rd_after_abort", 1'b1, 1'b0, 2'd3, 64'h40, 64'h0);

    // Random aligned write/read pairs.
    for (int n = 0; n < 6; n++) begin
      rw   = 2'($urandom_range(0, 3));
      rl   = 3'($urandom_range(0, 7)) & ~3'((1 << rw) - 1);
      ra   = {49'd0, 12'($urandom_range(16, 31)), rl};
      rdat = {$urandom, $urandom};
      xfer("rnd_wr", 1'b0, 1'b1, rw, ra, rdat);
      xfer("rnd_rd", 1'b1, 1'b0, rw, ra, 64'h0);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
